bvashr_sle_witness_checker: RTL and testbench
=============================================

// Module: bvashr_sle_witness_checker
// PURPOSE
//  Consumer-side checker for the bvsle/bvashr invertibility Skolem generators.
//  Accepts a triple (s, t, x), where x is the witness a generator produced.
//  - Decides whether x satisfies bvsle(bvashr(x, s), t).
//  - Decides, by sequential exhaustive search, whether any witness exists.
//  - Counts generator failures: cases where a witness exists but x is not one.
//  Sits after a generator netlist in the regression harness.
// PARAMETERS
//  W      4   operand width of s, t, x (2..8)
//  CNT_W  16  width of the saturating failure counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   1      request triple valid
//  req_ready    out  1      checker idle, can accept a request
//  req_s        in   W      shift amount, unsigned
//  req_t        in   W      bound, two's complement
//  req_x        in   W      candidate witness from the generator
//  rsp_valid    out  1      result valid, held until rsp_ready
//  rsp_ready    in   1      consumer accepts the result
//  rsp_pass     out  1      req_x satisfies the constraint
//  rsp_exists   out  1      some x in [0, 2^W-1] satisfies the constraint
//  rsp_witness  out  W      req_x if pass; else first satisfying y; else 0
//  fail_count   out  CNT_W  saturating count of responses with exists=1 and pass=0
// BEHAVIOUR
//  Reset (async, any state)
//   - State goes to IDLE; all outputs 0 except req_ready=1.
//   - Any in-flight request is dropped. fail_count clears.
//  Shift rule: bvashr(v, s) = v shifted right by min(s, W-1), sign bit replicated.
//   Shifting by W-1 or more yields all sign bits. Compare is signed.
//  IDLE
//   - req_ready=1. On req_valid & req_ready, latch s, t, x.
//   - Load shreg=x and shcnt=min(s, W-1).
//   - Go to SHIFT; go straight to COMPARE if shcnt=0.
//  SHIFT
//   - One arithmetic bit per cycle: shreg <= {shreg[W-1], shreg[W-1:1]}, shcnt--.
//   - Leave for COMPARE in the cycle shcnt reaches 0.
//  COMPARE (one cycle)
//   - pass = ($signed(shreg) <= $signed(t)).
//   - pass=1: exists=1, witness=x, go to DONE.
//   - pass=0: y=0, go to SEARCH.
//  SEARCH
//   - Evaluate y each cycle, using combinational ashr_sat from the package.
//   - Hit: exists=1, witness=y, go to DONE.
//   - Miss at y=2^W-1: exists=0, witness=0, go to DONE. Otherwise y++.
//   - The y counter is W+1 bits wide so the last value cannot wrap.
//  DONE
//   - rsp_valid=1; outputs stay stable until rsp_ready.
//   - On rsp_ready: go to IDLE.
//   - fail_count increments in the same cycle if exists & ~pass; saturates at 2^CNT_W-1.
//  Timing and flow
//   - req_ready=0 in every state except IDLE. No request overlap and no request queue.
//   - Latency from accept to rsp_valid: min(s, W-1) + 2 cycles when pass.
//   - Search adds (y_hit+1) cycles, or 2^W cycles on a miss.
//   - rsp_ready while rsp_valid=0 is ignored.
//   - A request arriving in the DONE->IDLE cycle is accepted on the next cycle.
// STRUCTURE
//  Package bvinv_pkg holds:
//   - localparam W_DEF=4
//   - state enum {IDLE, SHIFT, COMPARE, SEARCH, DONE}
//   - function ashr_sat(v, s)
//   - function sle(a, b)
//  Sub-module bv_ashr_serial (load, step, busy, q) holds shreg and shcnt.
//  The top level keeps the FSM, search counter, response registers and fail counter.
// TESTING (W=4)
//  1. s=2, t=0, x=4'b1100: 2 shift cycles -> pass=1, exists=1, witness=1100,
//     rsp_valid 4 cycles after accept.
//  2. s=9, t=0, x=4'b0111: shift capped at 3 -> 0000 <= 0, pass=1.
//  3. s=0, t=4'b1000, x=4'b0000: pass=0; search hits y=8 -> exists=1, witness=1000,
//     fail_count=1.
//  4. s=1, t=4'b1000, x=4'b1000: ashr result is -4 > -8, so pass=0;
//     search misses all 16 -> exists=0, witness=0, fail_count unchanged.
//  5. Hold rsp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0;
//     assert rsp_ready -> IDLE next cycle.
//  6. Assert rst mid-SEARCH -> rsp_valid=0, req_ready=1, fail_count=0 immediately;
//     next request completes normally.

Source files
------------

// File: rtl/bvinv_pkg.sv
// Shared types and helpers for the bvsle/bvashr invertibility witness checker.
// The bit-vector helpers work on an 8-bit container (the widest supported
// operand) and take the live operand width as an argument.
package bvinv_pkg;

    localparam int W_DEF = 4;
    localparam int W_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMPARE,
        SEARCH,
        DONE
    } state_t;

    // Sign-extend the low w bits of v to the full 8-bit container.
    function automatic logic [7:0] sext(input logic [7:0] v, input int unsigned w);
        logic [7:0] tmp;
        tmp = v << (W_MAX - w);
        return 8'($signed(tmp) >>> (W_MAX - w));
    endfunction

    // Arithmetic shift right of a w-bit value, with the shift amount capped at
    // w-1 so that oversized shifts yield all sign bits.
    function automatic logic [7:0] ashr_sat(input logic [7:0] v, input logic [7:0] s,
                                            input int unsigned w);
        int unsigned s32;
        int unsigned amt;
        logic [7:0]  ext;
        s32 = {24'b0, s};
        amt = (s32 > (w - 1)) ? (w - 1) : s32;
        ext = sext(v, w);
        return 8'($signed(ext) >>> amt);
    endfunction

    // Signed less-or-equal of two w-bit two's complement values.
    function automatic logic sle(input logic [7:0] a, input logic [7:0] b,
                                 input int unsigned w);
        logic [7:0] ae;
        logic [7:0] be;
        ae = sext(a, w);
        be = sext(b, w);
        return ($signed(ae) <= $signed(be));
    endfunction

endpackage

// File: rtl/bv_ashr_serial.sv
// Bit-serial arithmetic right shifter: loads a value and a shift count, then
// moves one bit per step while the count is non-zero, replicating the sign.
module bv_ashr_serial #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] d,
    input  logic [W-1:0] amt,
    output logic         busy,
    output logic         last,
    output logic [W-1:0] q
);

    logic [W-1:0] shreg;
    logic [W-1:0] shcnt;

    // Load takes priority; otherwise each step shifts one bit and counts down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            shcnt <= '0;
        end else if (load) begin
            shreg <= d;
            shcnt <= amt;
        end else if (step && (shcnt != '0)) begin
            shreg <= {shreg[W-1], shreg[W-1:1]};
            shcnt <= shcnt - 1'b1;
        end
    end

    // last flags the step that brings the count to zero, so the caller can
    // leave its shift phase in that same cycle.
    always_comb begin
        busy = (shcnt != '0);
        last = (shcnt == W'(1));
        q    = shreg;
    end

endmodule

// File: rtl/bvashr_sle_witness_checker.sv
// Checks a generator's witness x against bvsle(bvashr(x, s), t), searches all
// x exhaustively when the witness fails, and counts generator failures.
module bvashr_sle_witness_checker
    import bvinv_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_s,
    input  logic [W-1:0]     req_t,
    input  logic [W-1:0]     req_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_pass,
    output logic             rsp_exists,
    output logic [W-1:0]     rsp_witness,
    output logic [CNT_W-1:0] fail_count
);

    localparam logic [W-1:0]     SH_MAX  = W'(W - 1);
    localparam logic [W:0]       Y_LAST  = {1'b0, {W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t       state;
    logic [W-1:0] s_lat;
    logic [W-1:0] t_lat;
    logic [W-1:0] x_lat;
    logic [W:0]   y;

    logic [W-1:0] shamt;
    logic         sh_load;
    logic         sh_step;
    logic         sh_busy;
    logic         sh_last;
    logic [W-1:0] sh_q;
    logic         cmp_pass;
    logic [7:0]   y_shifted;
    logic         y_hit;

    // Saturated shift amount and the per-cycle compare results for the
    // witness path and the search path.
    always_comb begin
        shamt     = (req_s > SH_MAX) ? SH_MAX : req_s;
        sh_load   = (state == IDLE) && req_valid;
        sh_step   = (state == SHIFT) && sh_busy;
        cmp_pass  = sle(8'(sh_q), 8'(t_lat), W);
        y_shifted = ashr_sat(8'(y[W-1:0]), 8'(s_lat), W);
        y_hit     = sle(y_shifted, 8'(t_lat), W);
    end

    bv_ashr_serial #(.W(W)) u_shift (
        .clk  (clk),
        .rst  (rst),
        .load (sh_load),
        .step (sh_step),
        .d    (req_x),
        .amt  (shamt),
        .busy (sh_busy),
        .last (sh_last),
        .q    (sh_q)
    );

    // Main FSM with registered response outputs and the saturating failure counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_pass    <= 1'b0;
            rsp_exists  <= 1'b0;
            rsp_witness <= '0;
            fail_count  <= '0;
            s_lat       <= '0;
            t_lat       <= '0;
            x_lat       <= '0;
            y           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        s_lat     <= req_s;
                        t_lat     <= req_t;
                        x_lat     <= req_x;
                        req_ready <= 1'b0;
                        state     <= (shamt == '0) ? COMPARE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (sh_last || !sh_busy) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cmp_pass) begin
                        rsp_pass    <= 1'b1;
                        rsp_exists  <= 1'b1;
                        rsp_witness <= x_lat;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        y     <= '0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (y_hit) begin
                        rsp_exists  <= 1'b1;
                        rsp_witness <= y[W-1:0];
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (y == Y_LAST) begin
                        rsp_exists  <= 1'b0;
                        rsp_witness <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        y <= y + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        if (rsp_exists && !rsp_pass && (fail_count != CNT_MAX)) begin
                            fail_count <= fail_count + 1'b1;
                        end
                        rsp_valid   <= 1'b0;
                        rsp_pass    <= 1'b0;
                        rsp_exists  <= 1'b0;
                        rsp_witness <= '0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bvashr_sle_witness_checker.sv
// Self-checking bench for bvashr_sle_witness_checker at W=4 with a narrow
// failure counter so that saturation is reachable.
module tb_bvashr_sle_witness_checker;

    localparam int W     = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_s;
    logic [W-1:0]     req_t;
    logic [W-1:0]     req_x;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_pass;
    logic             rsp_exists;
    logic [W-1:0]     rsp_witness;
    logic [CNT_W-1:0] fail_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] t;
        logic [3:0] x;
        bit         pass;
        bit         exists;
        logic [3:0] witness;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    bvashr_sle_witness_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_s       (req_s),
        .req_t       (req_t),
        .req_x       (req_x),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_pass    (rsp_pass),
        .rsp_exists  (rsp_exists),
        .rsp_witness (rsp_witness),
        .fail_count  (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sext4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Arithmetic shift right as repeated floor-halving of the signed value.
    function automatic int floor_halve(input int v, input int n);
        int r = v;
        for (int i = 0; i < n; i++) r = (r < 0) ? (r - 1) / 2 : r / 2;
        return r;
    endfunction

    // Reference model: pass, exists, witness and accept-to-valid latency.
    task automatic model(input int s, input int t, input int x,
                         output bit p, output bit e, output int wit, output int lat);
        int amt;
        int hit;
        amt = (s > W - 1) ? W - 1 : s;
        p   = (floor_halve(sext4(x), amt) <= sext4(t));
        hit = -1;
        for (int y = 0; y < 16; y++) begin
            if (hit < 0 && floor_halve(sext4(y), amt) <= sext4(t)) hit = y;
        end
        e   = (hit >= 0);
        wit = p ? x : (e ? hit : 0);
        lat = amt + 2 + (p ? 0 : (e ? hit + 1 : 16));
    endtask

    // One full transaction: request, wait for response, optional hold, handshake.
    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x,
                                 input bit ep, input bit ee, input logic [3:0] ew,
                                 input int elat, input int hold, input bit early,
                                 input string tag);
        int  edges;
        int  waitc;
        bit  got;
        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            checkOutput({tag, " req_ready timeout"}, 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_s     = s;
        req_t     = t;
        req_x     = x;
        rsp_ready = early;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            checkOutput({tag, " rsp_valid timeout"}, 0, 1);
            rsp_ready = 1'b0;
            return;
        end
        checkOutput({tag, " latency"}, edges, elat);
        checkOutput({tag, " pass"}, rsp_pass, ep);
        checkOutput({tag, " exists"}, rsp_exists, ee);
        checkOutput({tag, " witness"}, rsp_witness, ew);
        checkOutput({tag, " req_ready busy"}, req_ready, 0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, " hold valid"}, rsp_valid, 1);
                checkOutput({tag, " hold witness"}, rsp_witness, ew);
                checkOutput({tag, " hold req_ready"}, req_ready, 0);
            end
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (ee && !ep && exp_fc < CMAX) exp_fc++;
        checkOutput({tag, " rsp_valid after ack"}, rsp_valid, 0);
        checkOutput({tag, " req_ready after ack"}, req_ready, 1);
        checkOutput({tag, " fail_count"}, fail_count, exp_fc);
    endtask

    initial begin
        bit  mp;
        bit  me;
        int  mw;
        int  ml;
        int  rs;
        int  rt;
        int  rx;

        vecs[0] = '{4'd2, 4'd0,     4'b1100, 1'b1, 1'b1, 4'b1100, 4};
        vecs[1] = '{4'd9, 4'd0,     4'b0111, 1'b1, 1'b1, 4'b0111, 5};
        vecs[2] = '{4'd0, 4'b1000,  4'b0000, 1'b0, 1'b1, 4'b1000, 11};
        vecs[3] = '{4'd1, 4'b1000,  4'b1000, 1'b0, 1'b0, 4'b0000, 19};
        vecs[4] = '{4'd3, 4'b1111,  4'b0101, 1'b0, 1'b1, 4'b1000, 14};
        vecs[5] = '{4'd0, 4'd7,     4'b1111, 1'b1, 1'b1, 4'b1111, 2};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_s     = '0;
        req_t     = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_pass", rsp_pass, 0);
        checkOutput("reset rsp_exists", rsp_exists, 0);
        checkOutput("reset rsp_witness", rsp_witness, 0);
        checkOutput("reset fail_count", fail_count, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].s, vecs[i].t, vecs[i].x, vecs[i].pass, vecs[i].exists,
                          vecs[i].witness, vecs[i].lat, (i == 0) ? 10 : 1, 1'b0,
                          $sformatf("vec%0d", i));
        end

        applyStimulus(vecs[2].s, vecs[2].t, vecs[2].x, vecs[2].pass, vecs[2].exists,
                      vecs[2].witness, vecs[2].lat, 0, 1'b1, "early ready");

        @(negedge clk);
        req_valid = 1'b1;
        req_s     = 4'd1;
        req_t     = 4'b1000;
        req_x     = 4'b1000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset fail_count nonzero", (fail_count != 0), 1);
        rst = 1'b1;
        #1;
        checkOutput("midsearch reset rsp_valid", rsp_valid, 0);
        checkOutput("midsearch reset req_ready", req_ready, 1);
        checkOutput("midsearch reset fail_count", fail_count, 0);
        @(negedge clk);
        rst    = 1'b0;
        exp_fc = 0;
        applyStimulus(vecs[0].s, vecs[0].t, vecs[0].x, vecs[0].pass, vecs[0].exists,
                      vecs[0].witness, vecs[0].lat, 0, 1'b0, "after reset");

        for (int i = 0; i < 40; i++) begin
            rs = $urandom_range(0, 15);
            rt = $urandom_range(0, 15);
            rx = $urandom_range(0, 15);
            model(rs, rt, rx, mp, me, mw, ml);
            applyStimulus(4'(rs), 4'(rt), 4'(rx), mp, me, 4'(mw), ml,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                          $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
